// File: rtl/prach_pingpong_buffer.sv
// PRACH capture buffer: two banks that alternate per window, filled from an interleaved
// multi-antenna sample stream, with a done/ack handshake and a fixed-latency read port.
module prach_pingpong_buffer #(
  parameter int CHANNEL    = 0,
  parameter int NUM_ANT    = 2,
  parameter int DEPTH      = 1536,
  parameter int DW         = 16,
  parameter int RD_LATENCY = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            din_dq,
  input  logic                     din_dv,
  input  logic [7:0]               din_chn,
  input  logic [15:0]              din_sample_k,
  input  logic                     ctrl_enable,
  input  logic [15:0]              ctrl_time_offset,
  input  logic [15:0]              ctrl_len,
  output logic                     done_req,
  output logic                     done_bank,
  input  logic                     done_ack,
  input  logic                     rd_bank,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  input  logic                     rd_en,
  output logic [NUM_ANT*DW-1:0]    rd_data,
  output logic                     overflow,
  output logic                     abort,
  output logic [1:0]               state
);

  localparam int BW = NUM_ANT * DEPTH;
  localparam int MW = $clog2(2 * BW);
  localparam logic [MW-1:0] BANK1_BASE = MW'(BW);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_CAPTURE = 2'd2} state_t;

  // Handshake: done_req stays high while a full bank exists; a single-cycle done_ack
  // while done_req is high releases done_bank, the bank that completed first.
  state_t          state_q, state_n;
  logic            wr_bank_q, oldest_q, oldest_n;
  logic [1:0]      full_q, full_n;
  logic [15:0]     offset_q, len_q, len_c, rel_k;
  logic            load_c, wr_c, complete_c, abort_c, overflow_c;
  logic            overflow_q, abort_q;
  logic [MW-1:0]   wr_idx_c, wr_idx_q, bank_base, rd_base, lane_sel;
  logic            wr_en_q;
  logic [DW-1:0]   wr_data_q;
  logic            lane_hit, lane0_hit, in_window;
  logic [16:0]     k17, end17;
  logic [DW-1:0]   mem [2*BW];
  logic [NUM_ANT*DW-1:0] rd_word;
  logic [NUM_ANT*DW-1:0] rd_pipe [RD_LATENCY];

  always_comb begin
    lane_hit = 1'b0;
    lane_sel = '0;
    for (int l = 0; l < NUM_ANT; l++) begin
      if (din_chn == 8'(CHANNEL + 8 * l)) begin
        lane_hit = 1'b1;
        lane_sel = MW'(l);
      end
    end
  end

  assign lane0_hit = (din_chn == 8'(CHANNEL));
  assign k17       = {1'b0, din_sample_k};
  // Window end in 17 bits so windows straddling 65535 never see a matching k.
  assign end17     = {1'b0, offset_q} + {1'b0, len_q};
  assign in_window = (k17 >= {1'b0, offset_q}) && (k17 < end17);
  assign rel_k     = din_sample_k - offset_q;
  assign bank_base = wr_bank_q ? BANK1_BASE : '0;
  assign len_c     = (ctrl_len > 16'(DEPTH)) ? 16'(DEPTH) : ctrl_len;

  always_comb begin
    state_n    = state_q;
    load_c     = 1'b0;
    wr_c       = 1'b0;
    wr_idx_c   = '0;
    complete_c = 1'b0;
    abort_c    = 1'b0;
    overflow_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_enable) begin
          state_n = S_WAIT;
          load_c  = 1'b1;
        end
      end
      S_WAIT: begin
        if (din_dv && lane0_hit && (len_q != 16'd0) && (din_sample_k == offset_q)) begin
          if (full_q[wr_bank_q]) begin
            overflow_c = 1'b1;
          end else begin
            state_n  = S_CAPTURE;
            wr_c     = 1'b1;
            wr_idx_c = bank_base;
          end
        end
      end
      S_CAPTURE: begin
        if (din_dv && lane_hit) begin
          if (lane0_hit && (k17 == end17)) begin
            complete_c = 1'b1;
            state_n    = S_WAIT;
            load_c     = 1'b1;
          end else if (lane0_hit && (din_sample_k < offset_q)) begin
            abort_c = 1'b1;
            state_n = S_WAIT;
            load_c  = 1'b1;
          end else if (in_window) begin
            wr_c     = 1'b1;
            wr_idx_c = bank_base + MW'(rel_k) * MW'(NUM_ANT) + lane_sel;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (!ctrl_enable) begin
      state_n    = S_IDLE;
      load_c     = 1'b0;
      wr_c       = 1'b0;
      complete_c = 1'b0;
      abort_c    = 1'b0;
      overflow_c = 1'b0;
    end
  end

  // Release and completion may land in the same cycle; both apply.
  always_comb begin
    full_n = full_q;
    if (done_ack && done_req) full_n[done_bank] = 1'b0;
    if (complete_c) full_n[wr_bank_q] = 1'b1;
    oldest_n = oldest_q;
    if (complete_c) oldest_n = full_n[~wr_bank_q] ? ~wr_bank_q : wr_bank_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      oldest_q   <= 1'b0;
      offset_q   <= '0;
      len_q      <= '0;
      overflow_q <= 1'b0;
      abort_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_n;
      full_q     <= full_n;
      oldest_q   <= oldest_n;
      overflow_q <= overflow_c;
      abort_q    <= abort_c;
      wr_en_q    <= wr_c;
      wr_idx_q   <= wr_idx_c;
      wr_data_q  <= din_dq;
      if (complete_c) wr_bank_q <= ~wr_bank_q;
      if (load_c) begin
        offset_q <= ctrl_time_offset;
        len_q    <= len_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_q) mem[wr_idx_q] <= wr_data_q;
  end

  assign rd_base = rd_bank ? BANK1_BASE : '0;

  always_comb begin
    rd_word = '0;
    for (int l = 0; l < NUM_ANT; l++)
      rd_word[l*DW +: DW] = mem[rd_base + MW'(rd_addr) * MW'(NUM_ANT) + MW'(l)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= rd_en ? rd_word : '0;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign rd_data   = rd_pipe[RD_LATENCY-1];
  assign done_req  = |full_q;
  assign done_bank = (&full_q) ? oldest_q : full_q[1];
  assign overflow  = overflow_q;
  assign abort     = abort_q;
  assign state     = state_q;

endmodule
